// File: rtl/tm_sr_tx_sched_if.sv
// Bundle between the TM/SR transmit scheduler and its neighbours:
// request/ack flags from the request generator, the payload buffer read
// port and the byte stream towards the 11-bit line framer.
// master = scheduler side, slave = surrounding logic.
interface tm_sr_tx_sched_if;
  logic       tm_tx_rdy;
  logic       sr_tx_rdy;
  logic       pre_tm;
  logic       tm_tx_ack;
  logic       sr_tx_ack;
  logic       rd_en;
  logic       rd_sel;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       frame_done;

  modport master (
    input  tm_tx_rdy, sr_tx_rdy, pre_tm, rd_data, byte_ready,
    output tm_tx_ack, sr_tx_ack, rd_en, rd_sel, rd_addr,
           byte_out, byte_valid, busy, frame_done
  );

  modport slave (
    output tm_tx_rdy, sr_tx_rdy, pre_tm, rd_data, byte_ready,
    input  tm_tx_ack, sr_tx_ack, rd_en, rd_sel, rd_addr,
           byte_out, byte_valid, busy, frame_done
  );
endinterface

// File: rtl/tm_sr_tx_sched.sv
// TM/SR transmit scheduler. Grants pending TM (priority) or SR requests,
// then emits one frame byte-by-byte over valid/ready:
//   SYNC, ID, LEN, byte3, payload[0..LEN-1], CRC[15:8], CRC[7:0]
// CRC-16-CCITT (0x1021, init 0xFFFF, MSB-first) over everything but SYNC,
// advanced only on accepted bytes.
// Build option: define TX_SEQ_CNT_EN to send a shared 8-bit frame sequence
// counter as byte3 (counts completed frames); otherwise byte3 is 8'h00.
module tm_sr_tx_sched #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] TM_ID     = 8'h01,
  parameter logic [7:0] SR_ID     = 8'h02,
  parameter int         TM_LEN    = 62,
  parameter int         SR_LEN    = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  tm_sr_tx_sched_if.master  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] CRC_H = 3'd4;
  localparam logic [2:0] CRC_L = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [15:0] POLY    = 16'h1021;
  localparam logic [5:0]  TM_LAST = 6'(TM_LEN - 1);
  localparam logic [5:0]  SR_LAST = 6'(SR_LEN - 1);

  logic [2:0]  state;
  logic [1:0]  hdr_cnt;
  logic [5:0]  idx;
  logic [5:0]  last_idx;
  logic        sel;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [7:0]  byte_p0;
  logic        vld_p0;
  logic        done_p0;
  logic        tm_ack;
  logic        sr_ack;
  logic        xfer;
  logic        grant;
  logic [7:0]  seq_byte;

  // One CRC-16-CCITT step over a byte, MSB first, no reflection.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c,
                                            input logic [7:0]  d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  // Service byte n of the header for the selected buffer.
  function automatic logic [7:0] hdr_byte(input logic [1:0] n,
                                          input logic       s,
                                          input logic [7:0] b3);
    logic [7:0] r;
    case (n)
      2'd0:    r = SYNC_BYTE;
      2'd1:    r = s ? SR_ID : TM_ID;
      2'd2:    r = s ? 8'(SR_LEN) : 8'(TM_LEN);
      default: r = b3;
    endcase
    return r;
  endfunction

  assign xfer     = vld_p0 & bus.byte_ready;
  assign crc_next = crc16_upd(crc, byte_p0);
  assign last_idx = sel ? SR_LAST : TM_LAST;
  assign grant    = bus.tm_tx_rdy | (bus.sr_tx_rdy & ~bus.pre_tm);

`ifdef TX_SEQ_CNT_EN
  logic [7:0] seq_cnt;

  // Frame sequence number: advances once per completed frame, wraps at 255.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       seq_cnt <= 8'h00;
    else if (done_p0) seq_cnt <= seq_cnt + 8'h01;
  end

  assign seq_byte = seq_cnt;
`else
  assign seq_byte = 8'h00;
`endif

  // Frame sequencer: grant, header, fetch/present payload, CRC, done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      hdr_cnt <= 2'd0;
      idx     <= 6'd0;
      sel     <= 1'b0;
      crc     <= 16'hFFFF;
      byte_p0 <= 8'h00;
      vld_p0  <= 1'b0;
      done_p0 <= 1'b0;
      tm_ack  <= 1'b0;
      sr_ack  <= 1'b0;
    end else begin
      tm_ack  <= 1'b0;
      sr_ack  <= 1'b0;
      done_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tm_ack  <= bus.tm_tx_rdy;
            sr_ack  <= ~bus.tm_tx_rdy;
            sel     <= ~bus.tm_tx_rdy;
            state   <= HDR;
            hdr_cnt <= 2'd0;
            idx     <= 6'd0;
            crc     <= 16'hFFFF;
            byte_p0 <= SYNC_BYTE;
            vld_p0  <= 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            // SYNC is outside the CRC
            if (hdr_cnt != 2'd0) crc <= crc_next;
            if (hdr_cnt == 2'd3) begin
              vld_p0  <= 1'b0;
              byte_p0 <= 8'h00;
              state   <= FETCH;
            end else begin
              hdr_cnt <= hdr_cnt + 2'd1;
              byte_p0 <= hdr_byte(hdr_cnt + 2'd1, sel, seq_byte);
            end
          end
        end
        FETCH: begin
          state <= DATA;
        end
        DATA: begin
          // first DATA cycle: buffer output is valid, capture it
          if (!vld_p0) begin
            byte_p0 <= bus.rd_data;
            vld_p0  <= 1'b1;
          end else if (xfer) begin
            crc <= crc_next;
            if (idx == last_idx) begin
              idx     <= 6'd0;
              state   <= CRC_H;
              byte_p0 <= crc_next[15:8];
            end else begin
              idx     <= idx + 6'd1;
              vld_p0  <= 1'b0;
              state   <= FETCH;
            end
          end
        end
        CRC_H: begin
          if (xfer) begin
            byte_p0 <= crc[7:0];
            state   <= CRC_L;
          end
        end
        CRC_L: begin
          if (xfer) begin
            vld_p0  <= 1'b0;
            byte_p0 <= 8'h00;
            done_p0 <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          vld_p0 <= 1'b0;
        end
      endcase
    end
  end

  // ---- output stage ----
  assign bus.tm_tx_ack  = tm_ack;
  assign bus.sr_tx_ack  = sr_ack;
  assign bus.rd_en      = (state == FETCH);
  assign bus.rd_sel     = sel;
  assign bus.rd_addr    = idx;
  assign bus.byte_out   = byte_p0;
  assign bus.byte_valid = vld_p0;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = done_p0;

endmodule

// File: doc/tm_sr_tx_sched.md
Name: tm_sr_tx_sched

Overview:
Transmit scheduler directly downstream of the TM/SR request generator. It consumes the tm_tx_rdy / sr_tx_rdy request flags and pre_tm, and returns one-cycle acks. For each granted request it assembles a frame: 4 service bytes, payload bytes read from the TM or SR buffer, and a CRC-16. Bytes go out one at a time over a valid/ready handshake to the 11-bit line framer.

Parameters:
SYNC_BYTE, 8'hA5, service byte 0 (frame sync)
TM_ID, 8'h01, service byte 1 value for TM frames
SR_ID, 8'h02, service byte 1 value for SR frames
TM_LEN, 62, TM payload byte count (1..62)
SR_LEN, 16, SR payload byte count (1..62)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
tm_tx_rdy  in  1  TM frame pending (level)
sr_tx_rdy  in  1  SR frame pending (level)
pre_tm  in  1  TM slot imminent; do not start SR
tm_tx_ack  out  1  1-cycle pulse: TM request granted
sr_tx_ack  out  1  1-cycle pulse: SR request granted
rd_en  out  1  payload buffer read strobe
rd_sel  out  1  0 = TM buffer, 1 = SR buffer
rd_addr  out  6  payload byte index
rd_data  in  8  buffer data, valid 1 cycle after rd_en
byte_out  out  8  byte to framer
byte_valid  out  1  byte_out valid
byte_ready  in  1  framer accepts byte on valid&ready
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  1-cycle pulse after last CRC byte is accepted

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register 16'hFFFF; byte index 0. An async reset mid-frame aborts the frame immediately. No ack is reissued after an abort.
- States and transitions:
  - IDLE -> HDR on grant.
  - HDR (4 bytes) -> FETCH.
  - FETCH -> DATA.
  - DATA -> FETCH while bytes remain, else -> CRC_H.
  - CRC_H -> CRC_L.
  - CRC_L -> DONE.
  - DONE -> IDLE (one cycle; frame_done=1).
- Grant in IDLE only; TM has priority.
  - tm_tx_rdy=1: grant TM; tm_tx_ack=1 for one cycle; rd_sel latched 0.
  - Otherwise sr_tx_rdy=1 and pre_tm=0: grant SR; sr_tx_ack=1; rd_sel latched 1.
  - sr_tx_rdy=1 with pre_tm=1: no grant; wait in IDLE.
  - Both rdy high: TM granted. SR stays pending (no ack) and is granted after this frame, subject to pre_tm.
  - Requests arriving while busy are not acked until the next IDLE.
- Acks are issued only in the cycle of the IDLE->HDR transition. The upstream clears rdy on ack, and a rdy re-asserted by upstream in that same cycle must be served again.
- Service bytes, in order:
  - byte0 = SYNC_BYTE
  - byte1 = TM_ID or SR_ID
  - byte2 = payload length (TM_LEN or SR_LEN)
  - byte3 = 8'h00 (see the optional feature)
- Payload:
  - FETCH drives rd_en=1 and rd_addr=index for one cycle.
  - DATA captures rd_data the next cycle and presents it with byte_valid=1.
  - Index runs 0..LEN-1, then returns to 0.
- Byte handshake:
  - byte_out and byte_valid hold stable until byte_ready. Transfer occurs on the cycle byte_valid&byte_ready.
  - byte_valid is never deasserted without a transfer.
  - Zero bubble requirement only within HDR/CRC. One idle cycle per payload byte (FETCH) is allowed.
- CRC:
  - CRC-16-CCITT: poly 16'h1021, init 16'hFFFF, MSB-first, no reflection, no final XOR.
  - Covers bytes 1..3 plus the payload; SYNC_BYTE is excluded.
  - CRC updates only on accepted bytes.
  - CRC_H sends crc[15:8], CRC_L sends crc[7:0].
  - CRC reinitialised to 16'hFFFF on each grant.
- Total frame length = 4 + LEN + 2 bytes (68 for TM with default parameters).

Optional Feature:
- Macro TX_SEQ_CNT_EN.
- Defined: an 8-bit sequence counter, reset 0, is sent as service byte 3 and included in the CRC. It increments by 1 on each frame_done and wraps 255->0. TM and SR share one counter. An aborted frame does not increment it.
- Undefined: byte 3 = 8'h00 and no counter register exists.

Test Plan:
- TM only, byte_ready tied 1, TM buffer[i]=i:
  - tm_tx_ack pulses once.
  - Stream A5 01 3E 00 00..3D, then CRC matching the model (model check: "123456789" -> 0x29B1).
  - 68 bytes total; frame_done one cycle after the last byte.
- tm_tx_rdy and sr_tx_rdy asserted in the same cycle:
  - TM frame first; sr_tx_ack absent until TM frame_done.
  - Then SR frame A5 02 10 00 + 16 bytes + CRC.
- sr_tx_rdy=1 with pre_tm=1 for 20 cycles:
  - No sr_tx_ack and busy=0 throughout.
  - pre_tm drops -> sr_tx_ack on the next cycle.
- Framer backpressure, byte_ready random 30% duty:
  - byte_out stable while valid&!ready.
  - Byte sequence and CRC identical to the ready=1 run.
- n_rst pulsed low during payload byte 10:
  - All outputs 0 immediately; state IDLE.
  - A new tm_tx_rdy yields a full 68-byte frame starting with A5.
- TX_SEQ_CNT_EN defined, 3 back-to-back TM frames:
  - byte3 = 00, 01, 02.
  - CRC matches the model including byte3.
